proc_sequencer: RTL
===================

Name: proc_sequencer

Overview:
- Instruction sequencer for the 4-bit processor datapath. Steps a program counter through the program ROM and fetches one 4-bit opcode per instruction.
- For each instruction: reads the operand word from data RAM, drives the ULA with the operands and opcode, then writes the 8-bit ULA result back to RAM and to a result register.
- Supports free-run and single-step modes, plus a HALT opcode.
- Sits between the board I/O (keys/LEDs) and the program_rom, data_ram and ula_3bits instances.

Parameters:
- PROG_LEN, 16: number of program words executed before auto-stop (2..16).
- HALT_OP, 4'hF: opcode that stops execution without a write-back.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a run from pc=0.
- step_mode  in  1  1 = pause after each instruction.
- step  in  1  one-cycle pulse; releases the next instruction in step mode.
- prom_addr  out  4  program ROM address (= pc).
- prom_data  in  4  program ROM output; synchronous read, 1-cycle latency.
- dram_addr  out  1  data RAM address: 0 = operand word, 1 = result word.
- dram_we  out  1  data RAM write enable.
- dram_wdata  out  8  data RAM write data.
- dram_rdata  in  8  data RAM read data; synchronous read, 1-cycle latency.
- ula_a  out  4  ULA operand A = operand word [3:0].
- ula_b  out  4  ULA operand B = operand word [7:4].
- ula_op  out  4  ULA opcode.
- ula_out  in  8  ULA result (combinational).
- pc  out  4  current program counter.
- result  out  8  last written-back result.
- result_valid  out  1  one-cycle pulse when result updates.
- busy  out  1  high whenever state is not IDLE or DONE.
- done  out  1  high in DONE.
- state_dbg  out  3  encoded state, for LEDG.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; pc, op_reg, opa_reg, opb_reg, result all 0.
  - result_valid=0, done=0, busy=0.
  - dram_we is gated by ~rst, so no write occurs in the reset cycle even if the state is WRITE.
  - Reset mid-run aborts the instruction with no partial write.
- State encoding (state_dbg): IDLE=0, FETCH=1, DECODE=2, READ=3, EXEC=4, WRITE=5, NEXT=6, WAIT_STEP / DONE = 7.
  - done distinguishes the two states that share code 7.
- prom_addr=pc at all times. ula_op=op_reg, ula_a=opa_reg, ula_b=opb_reg at all times.
- State transitions, one cycle each:
  - IDLE: start -> FETCH with pc=0.
  - FETCH: ROM samples pc at the end of this cycle -> DECODE.
  - DECODE: op_reg<=prom_data. If prom_data==HALT_OP -> DONE (pc held, no RAM access); else -> READ.
  - READ: dram_addr=0, dram_we=0 -> EXEC.
  - EXEC: opa_reg<=dram_rdata[3:0], opb_reg<=dram_rdata[7:4] -> WRITE.
  - WRITE: ULA now sees the registered operands. dram_addr=1, dram_we=1, dram_wdata=ula_out; result<=ula_out; result_valid=1 on the next cycle only -> NEXT.
  - NEXT:
    - If pc==PROG_LEN-1 -> DONE, pc unchanged.
    - Else pc<=pc+1, then -> WAIT_STEP if step_mode=1, otherwise -> FETCH.
    - step_mode is sampled only in NEXT.
  - WAIT_STEP: step -> FETCH. start is ignored here; if start and step arrive together, step wins.
  - DONE: start -> FETCH with pc=0. Stays in DONE otherwise.
- Latency: 6 cycles per instruction in free-run. First prom_addr-valid FETCH occurs 1 cycle after start.
- start is ignored in every state except IDLE and DONE. step is ignored outside WAIT_STEP.
- dram_addr defaults to 0 and dram_we to 0 in every state except WRITE.
- Only WRITE touches RAM address 1; the operand word at address 0 is never written by this block.

Test Plan:
- Bench ULA stub is ula_out = ula_a*ula_b; RAM[0]=8'h32; ROM = {2,2,2,...}, PROG_LEN=3, step_mode=0.
  - Apply start -> three result_valid pulses, 6 cycles apart.
  - result=8'h06 each time, RAM[1]=8'h06.
  - DONE 1 cycle after the third NEXT, pc=2, busy=0, done=1.
- ROM[0]=1, ROM[1]=HALT_OP, PROG_LEN=16 -> exactly one write-back; DONE reached from DECODE with pc=1; dram_we never high at pc=1.
- step_mode=1, PROG_LEN=4 -> after the first write-back, state_dbg=7, done=0, pc=1.
  - No progress for 20 cycles.
  - Each step pulse yields exactly one more result_valid.
  - start pulses in WAIT_STEP have no effect.
- Assert rst during the WRITE of instruction 2 -> dram_we=0 in that cycle, RAM[1] keeps instruction 1's value, all outputs return to reset values next cycle.
- From DONE, change RAM[0]=8'hFF and pulse start -> pc restarts at 0, result=8'hE1; start pulsed while busy is ignored (pc sequence is unchanged).

Source files
------------

// File: rtl/proc_sequencer.sv
// Instruction sequencer: fetches opcodes from the program ROM, reads the operand
// word from data RAM, drives the ULA and writes each result back to RAM word 1.
module proc_sequencer #(
    parameter int         PROG_LEN = 16,
    parameter logic [3:0] HALT_OP  = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       step_mode,
    input  logic       step,
    output logic [3:0] prom_addr,
    input  logic [3:0] prom_data,
    output logic       dram_addr,
    output logic       dram_we,
    output logic [7:0] dram_wdata,
    input  logic [7:0] dram_rdata,
    output logic [3:0] ula_a,
    output logic [3:0] ula_b,
    output logic [3:0] ula_op,
    input  logic [7:0] ula_out,
    output logic [3:0] pc,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       busy,
    output logic       done,
    output logic [2:0] state_dbg
);

    // Handshake: start and step are single-cycle pulses with no ready; start is
    // accepted only in IDLE/DONE, step only in WAIT_STEP, and step wins if both.
    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_WRITE,
        S_NEXT,
        S_WAIT_STEP,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_PC = 4'(PROG_LEN - 1);

    state_t     state;
    state_t     state_nx;
    logic [3:0] op_reg;
    logic [3:0] opa_reg;
    logic [3:0] opb_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= 4'd0;
            op_reg       <= 4'd0;
            opa_reg      <= 4'd0;
            opb_reg      <= 4'd0;
            result       <= 8'd0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nx;
            result_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) pc <= 4'd0;
                end
                S_DECODE: op_reg <= prom_data;
                S_EXEC: begin
                    opa_reg <= dram_rdata[3:0];
                    opb_reg <= dram_rdata[7:4];
                end
                S_WRITE: begin
                    result       <= ula_out;
                    result_valid <= 1'b1;
                end
                S_NEXT: begin
                    if (pc != LAST_PC) pc <= pc + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx   = state;
        dram_addr  = 1'b0;
        dram_we    = 1'b0;
        dram_wdata = ula_out;
        busy       = 1'b1;
        done       = 1'b0;
        state_dbg  = 3'd0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = S_FETCH;
            end
            S_FETCH: begin
                state_dbg = 3'd1;
                state_nx  = S_DECODE;
            end
            S_DECODE: begin
                state_dbg = 3'd2;
                state_nx  = (prom_data == HALT_OP) ? S_DONE : S_READ;
            end
            S_READ: begin
                state_dbg = 3'd3;
                state_nx  = S_EXEC;
            end
            S_EXEC: begin
                state_dbg = 3'd4;
                state_nx  = S_WRITE;
            end
            S_WRITE: begin
                // Write is suppressed while rst is high so a reset never leaves a partial result.
                state_dbg = 3'd5;
                dram_addr = 1'b1;
                dram_we   = ~rst;
                state_nx  = S_NEXT;
            end
            S_NEXT: begin
                state_dbg = 3'd6;
                if (pc == LAST_PC)  state_nx = S_DONE;
                else if (step_mode) state_nx = S_WAIT_STEP;
                else                state_nx = S_FETCH;
            end
            S_WAIT_STEP: begin
                state_dbg = 3'd7;
                if (step) state_nx = S_FETCH;
            end
            S_DONE: begin
                state_dbg = 3'd7;
                busy      = 1'b0;
                done      = 1'b1;
                if (start) state_nx = S_FETCH;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign prom_addr = pc;
    assign ula_op    = op_reg;
    assign ula_a     = opa_reg;
    assign ula_b     = opb_reg;

endmodule
